// File: rtl/chan_mux_pkg.sv
// chan_mux_pkg: shared encodings for the channel scan multiplexer.
// Holds the mode and FSM state constants used by chan_scan_mux.
package chan_mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_FULL = 1'b1;

endpackage

// File: rtl/chan_sel_comb.sv
// chan_sel_comb: combinational W-bit N:1 channel selector.
// Ports: in (N*W packed), idx (SW) -> dout (W), oor (idx >= N; dout is 0).
module chan_sel_comb
  import chan_mux_pkg::*;
#(
  parameter int N  = 16,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic [N*W-1:0] in,
  input  logic [SW-1:0]  idx,
  output logic [W-1:0]   dout,
  output logic           oor
);

  logic hit;

  // An index matching no channel leaves dout at zero.
  always_comb begin
    dout = '0;
    hit  = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (idx == SW'(k)) begin
        dout = in[k*W +: W];
        hit  = 1'b1;
      end
    end
    oor = !hit;
  end

endmodule

// File: rtl/chan_scan_mux.sv
// chan_scan_mux: registered N:1 mux of W-bit channels, manual or scan mode.
// Ports: clk, rst, in, sel, mode, en, y_ready -> y, y_valid, y_chan, sel_err.
module chan_scan_mux
  import chan_mux_pkg::*;
#(
  parameter int N  = 16,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in,
  input  logic [SW-1:0]  sel,
  input  logic           mode,
  input  logic           en,
  input  logic           y_ready,
  output logic [W-1:0]   y,
  output logic           y_valid,
  output logic [SW-1:0]  y_chan,
  output logic           sel_err
);

  localparam logic [SW-1:0] LAST = SW'(N - 1);

  logic          state;
  logic [SW-1:0] ptr;
  logic [SW-1:0] c;
  logic [W-1:0]  cdata;
  logic          coor;
  logic          scan;
  logic          load;
  logic          drain;

  assign scan  = (mode == MODE_SCAN);
  assign c     = scan ? ptr : sel;
  assign load  = en && ((state == ST_IDLE) || y_ready);
  assign drain = (state == ST_FULL) && y_ready && !en;

  chan_sel_comb #(
    .N  (N),
    .W  (W),
    .SW (SW)
  ) u_sel (
    .in   (in),
    .idx  (c),
    .dout (cdata),
    .oor  (coor)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      y       <= '0;
      y_chan  <= '0;
      sel_err <= 1'b0;
    end else begin
      // ptr only ever reaches LAST, so an out-of-range
      // flag can only come from the manual select.
      sel_err <= load && !scan && coor;
      if (load) begin
        state  <= ST_FULL;
        y      <= cdata;
        y_chan <= c;
        if (scan) begin
          ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
        end
      end else if (drain) begin
        state <= ST_IDLE;
      end
    end
  end

  assign y_valid = (state == ST_FULL);

endmodule

// File: tb/tb_chan_scan_mux.sv
// tb_chan_scan_mux: scoreboard bench for chan_scan_mux (N=16 and N=12).
// Stimulus pushes expected samples; a monitor pops on each accepted output.
module tb_chan_scan_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [127:0] in16;
  logic [3:0]   sel16;
  logic         mode16, en16, rdy16;
  logic [7:0]   y16;
  logic         v16, err16;
  logic [3:0]   ch16;

  logic [95:0]  in12;
  logic [3:0]   sel12;
  logic         mode12, en12, rdy12;
  logic [7:0]   y12;
  logic         v12, err12;
  logic [3:0]   ch12;

  chan_scan_mux #(.N(16), .W(8)) u16 (
    .clk(clk), .rst(rst), .in(in16), .sel(sel16),
    .mode(mode16), .en(en16), .y_ready(rdy16),
    .y(y16), .y_valid(v16), .y_chan(ch16), .sel_err(err16)
  );

  chan_scan_mux #(.N(12), .W(8)) u12 (
    .clk(clk), .rst(rst), .in(in12), .sel(sel12),
    .mode(mode12), .en(en12), .y_ready(rdy12),
    .y(y12), .y_valid(v12), .y_chan(ch12), .sel_err(err12)
  );

  int ncmp = 0;
  int nbad = 0;

  typedef struct packed {
    logic [7:0] d;
    logic [3:0] c;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch);
    exp_t e;
    e.d = 8'(8'hA0 + ch);
    e.c = 4'(ch);
    sb.push_back(e);
  endtask

  task automatic load16(input int ch);
    push(ch);
    cyc();
  endtask

  // An output is accepted at the edge following a cycle with valid && ready.
  always @(negedge clk) begin
    if (v16 && rdy16) begin
      if (sb.size() == 0) begin
        ncmp++;
        nbad++;
        $display("FAIL sb_extra: got chan %0d expected none", ch16);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_y", 32'(y16), 32'(e.d));
        chk("sb_chan", 32'(ch16), 32'(e.c));
      end
    end
  end

  initial begin
    rst = 1'b1;
    sel16 = '0; mode16 = 1'b0; en16 = 1'b0; rdy16 = 1'b0;
    sel12 = '0; mode12 = 1'b0; en12 = 1'b0; rdy12 = 1'b0;
    for (int k = 0; k < 16; k++) in16[k*8 +: 8] = 8'(8'hA0 + k);
    for (int k = 0; k < 12; k++) in12[k*8 +: 8] = 8'(8'hA0 + k);
    cyc();
    cyc();
    chk("rst_y", 32'(y16), 32'h0);
    chk("rst_valid", 32'(v16), 32'h0);
    chk("rst_chan", 32'(ch16), 32'h0);
    chk("rst_err", 32'(err16), 32'h0);
    rst = 1'b0;

    // Manual read of channel 5, then drain.
    mode16 = 1'b0; sel16 = 4'd5; en16 = 1'b1; rdy16 = 1'b1;
    push(5);
    cyc();
    en16 = 1'b0;
    chk("man_y", 32'(y16), 32'hA5);
    chk("man_chan", 32'(ch16), 32'd5);
    chk("man_valid", 32'(v16), 32'd1);
    chk("man_err", 32'(err16), 32'd0);
    cyc();
    chk("drain_valid", 32'(v16), 32'd0);

    // Scan 18 loads with wrap.
    mode16 = 1'b1; en16 = 1'b1; rdy16 = 1'b1;
    for (int i = 0; i < 18; i++) begin
      load16(i % 16);
      chk("scan_valid", 32'(v16), 32'd1);
    end

    // Load 2 and 3, then stall on 3.
    load16(2);
    load16(3);
    rdy16 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in16 = ~in16;
      sel16 = 4'(i * 5);
      mode16 = ~mode16;
      en16 = i[0];
      cyc();
      chk("stall_y", 32'(y16), 32'hA3);
      chk("stall_chan", 32'(ch16), 32'd3);
      chk("stall_valid", 32'(v16), 32'd1);
    end
    for (int k = 0; k < 16; k++) in16[k*8 +: 8] = 8'(8'hA0 + k);
    mode16 = 1'b1; en16 = 1'b1; rdy16 = 1'b1;
    load16(4);
    chk("release_chan", 32'(ch16), 32'd4);

    // Reset mid-stream with ptr at 7.
    load16(5);
    load16(6);
    rst = 1'b1;
    cyc();
    chk("mrst_y", 32'(y16), 32'h0);
    chk("mrst_valid", 32'(v16), 32'd0);
    chk("mrst_chan", 32'(ch16), 32'd0);
    rst = 1'b0;
    load16(0);
    chk("post_rst_y", 32'(y16), 32'hA0);

    // Scan to 9, two manual loads of 2, resume scan at 10.
    for (int i = 1; i <= 9; i++) load16(i);
    mode16 = 1'b0; sel16 = 4'd2;
    load16(2);
    load16(2);
    mode16 = 1'b1;
    load16(10);
    chk("resume_chan", 32'(ch16), 32'd10);
    en16 = 1'b0;
    cyc();
    cyc();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    // N=12 build: out-of-range manual select.
    mode12 = 1'b0; sel12 = 4'd13; en12 = 1'b1; rdy12 = 1'b1;
    cyc();
    en12 = 1'b0;
    chk("oor_y", 32'(y12), 32'h0);
    chk("oor_chan", 32'(ch12), 32'd13);
    chk("oor_valid", 32'(v12), 32'd1);
    chk("oor_err", 32'(err12), 32'd1);
    cyc();
    chk("oor_err_pulse", 32'(err12), 32'd0);
    chk("oor_drain", 32'(v12), 32'd0);
    sel12 = 4'd11; en12 = 1'b1;
    cyc();
    en12 = 1'b0;
    chk("n12_last_y", 32'(y12), 32'hAB);
    chk("n12_last_err", 32'(err12), 32'd0);

    // N=12 scan wraps after channel 11.
    mode12 = 1'b1; en12 = 1'b1;
    for (int i = 0; i < 13; i++) begin
      cyc();
      chk("n12_scan_chan", 32'(ch12), 32'(i % 12));
    end
    en12 = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
